dmem_arbiter: RTL and testbench

Arbiter sharing the toy CPU's single-port 16-bit data memory between the processor datapath and a host/debug port (UART loader, test harness). CPU has priority by default; the host gets any cycle the CPU does not use and, optionally, a forced slot after bounded starvation. It sits between the processor's memAddr/memWE/regSrcData/memData nets and the dataMem array. It drives a stall to the PC/register-file enables when the CPU loses a cycle.

---
 rtl/toycpu_pkg.sv | 18 +
 rtl/arb_starve_cnt.sv | 39 +++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/toycpu_pkg.sv
// Shared types and constants for the toy CPU memory subsystem.
// Revision 1.0
`default_nettype none

package toycpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CPU   = 2'd1,
        ARB_HOST  = 2'd2,
        ARB_FORCE = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
// Host starvation counter: saturating count of host-blocked cycles with a due flag.
// Built only when ARB_FAIR_EN is defined. Revision 1.0
`default_nettype none

`ifdef ARB_FAIR_EN
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic host_valid_i,
    input  logic host_gnt_i,
    output logic due_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = 4'd0;
        if (host_valid_i && !host_gnt_i) begin
            cnt_d = (cnt_q == 4'(STARVE_MAX)) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign due_o = (cnt_q == 4'(STARVE_MAX));

endmodule
`endif

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between CPU datapath and host/debug port; CPU has priority.
// ARB_FAIR_EN enables a forced host slot after STARVE_MAX blocked cycles. Revision 1.0
`default_nettype none

module dmem_arbiter
    import toycpu_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [DATA_W-1:0] host_rdata_q;
    logic              host_rvalid_q;
    logic              cpu_gnt;
    logic              host_gnt;
    logic              force_due;
    logic              mem_we_raw;

`ifdef ARB_FAIR_EN
    logic starve_due;

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk         (clk),
        .rst         (rst),
        .host_valid_i(host_valid),
        .host_gnt_i  (host_gnt),
        .due_o       (starve_due)
    );

    // A forced slot never follows another one, so the CPU always gets the next cycle.
    assign force_due = starve_due && host_valid && (state_q != ARB_FORCE);
`else
    logic unused_state;

    assign force_due    = 1'b0;
    assign unused_state = ^state_q;
`endif

    always_comb begin
        cpu_gnt  = cpu_req && !force_due;
        host_gnt = host_valid && !cpu_gnt;
        state_d  = ARB_IDLE;
        if (cpu_gnt) begin
            state_d = ARB_CPU;
        end else if (host_gnt) begin
            state_d = cpu_req ? ARB_FORCE : ARB_HOST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_rvalid_q <= host_gnt && !host_we;
            if (host_gnt && !host_we) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_we_raw = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = '0;
        if (cpu_gnt) begin
            mem_we_raw = cpu_we;
            mem_wdata  = cpu_wdata;
        end else if (host_gnt) begin
            mem_we_raw = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
        end
    end

    assign mem_we      = mem_we_raw && !rst;
    assign host_ready  = host_gnt && !rst;
    assign cpu_stall   = cpu_req && !cpu_gnt && !rst;
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus random traffic vs. a reference model.
// Revision 1.0
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW         = 10;
    localparam int STARVE_MAX = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          host_valid, host_we;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata, host_rdata;
    logic          host_ready, host_rvalid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT.
    logic [15:0] env_mem [0:1023];
    always @(posedge clk) if (mem_we) env_mem[mem_addr] = mem_wdata;
    assign mem_rdata = env_mem[mem_addr];

    // Reference model state.
    logic [15:0] ref_mem [0:1023];
    logic [15:0] exp_rdata;
    bit          exp_rvalid;
    int          starve;
    bit          last_force;
    int          owner;       // 0 none, 1 cpu, 2 host
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          host_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already set; check outputs, then advance model over the posedge.
    task automatic cycle();
        bit due;
        #3;
        due = FAIR && (starve == STARVE_MAX) && host_valid && !last_force;
        if (cpu_req && !due) owner = 1;
        else if (host_valid) owner = 2;
        else owner = 0;

        chk("rvalid", host_rvalid, exp_rvalid);
        chk("rdata", host_rdata, exp_rdata);
        chk("ready", host_ready, owner == 2);
        chk("stall", cpu_stall, cpu_req && owner != 1);
        if (owner == 1) begin
            chk("mem_we_cpu", mem_we, cpu_we);
            chk("mem_addr_cpu", mem_addr, cpu_addr);
            if (cpu_we) chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
            else        chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
        end else if (owner == 2) begin
            chk("mem_we_host", mem_we, host_we);
            chk("mem_addr_host", mem_addr, host_addr);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
            chk("mem_addr_idle", mem_addr, cpu_addr);
            chk("mem_wdata_idle", mem_wdata, 16'h0);
        end

        @(posedge clk);
        exp_rvalid = (owner == 2) && !host_we;
        if (exp_rvalid) exp_rdata = ref_mem[host_addr];
        if (owner == 1 && cpu_we)  ref_mem[cpu_addr]  = cpu_wdata;
        if (owner == 2 && host_we) ref_mem[host_addr] = host_wdata;
        if (host_valid && owner != 2) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        else starve = 0;
        last_force = (owner == 2) && cpu_req;
        #1;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_host(input bit v, input bit we, input logic [AW-1:0] a, input logic [15:0] d);
        host_valid = v; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        int ready_wait;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 16'(i * 16'h0101);
            ref_mem[i] = 16'(i * 16'h0101);
        end
        rst = 1'b1;
        set_cpu(0, 0, '0, '0);
        set_host(0, 0, '0, '0);
        exp_rvalid = 0; exp_rdata = '0; starve = 0; last_force = 0; owner = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", host_rvalid, 1'b0);
        chk("reset_rdata", host_rdata, 16'h0);
        rst = 1'b0;

        // CPU store then load.
        set_cpu(1, 1, 10'h012, 16'hBEEF); cycle();
        set_cpu(1, 0, 10'h012, 16'h0000); #3;
        chk("cpu_load_beef", cpu_rdata, 16'hBEEF);
        chk("cpu_load_nostall", cpu_stall, 1'b0);
        #1 cycle();

        // Host write then read at the top address.
        set_cpu(0, 0, '0, '0);
        set_host(1, 1, 10'h3FF, 16'h1234); cycle();
        set_host(1, 0, 10'h3FF, 16'h0000); cycle();
        set_host(0, 0, '0, '0); #3;
        chk("host_read_1234", host_rdata, 16'h1234);
        chk("host_rvalid_pulse", host_rvalid, 1'b1);
        #1 cycle();

        // Contention: CPU held 20 cycles, host waiting.
        ready_wait = 0;
        set_host(1, 0, 10'h012, '0);
        for (int i = 0; i < 20; i++) begin
            set_cpu(1, 0, 10'(i), '0);
            if (owner == 2) set_host(1, 0, 10'h012, '0);
            cycle();
            if (owner != 2) ready_wait++;
        end
        if (!FAIR) chk("strict_wait_20", ready_wait, 20);
        set_cpu(0, 0, '0, '0);
        cycle();
        chk("host_granted_21", owner, 2);

        // Simultaneous CPU store and host write to the same address.
        set_cpu(1, 1, 10'h020, 16'hAAAA);
        set_host(1, 1, 10'h020, 16'h5555); cycle();
        set_cpu(0, 0, '0, '0); cycle();
        set_host(1, 0, 10'h020, '0); cycle();
        set_host(0, 0, '0, '0); cycle();
        chk("same_addr_readback", exp_rdata, 16'h5555);

        // Reset in the middle of a host read.
        set_host(1, 0, 10'h3FF, '0); cycle();
        rst = 1'b1;
        set_cpu(1, 1, 10'h001, 16'hDEAD);
        set_host(1, 1, 10'h002, 16'hF00D);
        #3;
        chk("rst_rvalid", host_rvalid, 1'b0);
        chk("rst_rdata", host_rdata, 16'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_ready", host_ready, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rvalid = 0; exp_rdata = '0; starve = 0; last_force = 0;
        set_cpu(0, 0, '0, '0);
        set_host(0, 0, '0, '0);
        cycle();
        cycle();

        // Random traffic on a small address window; host holds its request until accepted.
        host_pend = 0;
        for (int i = 0; i < 400; i++) begin
            set_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                    10'($urandom_range(0, 15)), 16'($urandom));
            if (!host_pend && $urandom_range(0, 2) != 0) begin
                set_host(1, $urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)), 16'($urandom));
                host_pend = 1;
            end else if (!host_pend) begin
                host_valid = 0;
            end
            cycle();
            if (owner == 2) host_pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
